// File: rtl/pe_operand_dispatcher.sv
// pe_operand_dispatcher
//   Feeds a processing_element one operation at a time. Operand/opcode
//   triples arrive on a valid/ready stream into a FIFO. The FSM pops the
//   head, strobes pe_enable for one cycle, waits for the PE's registered
//   pe_valid (bounded by TIMEOUT_CYCLES), then presents the result or an
//   error on a valid/ready output stream. Only one op is in flight, so
//   results leave in arrival order.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   s_valid/s_ready       input stream handshake
//   s_op, s_a, s_b        opcode (1 ADD, 2 SUB, 3 MUL, 4 MAC) and operands
//   pe_enable             one-cycle issue strobe to the PE
//   pe_operation/op_a/b   held operation presented to the PE
//   pe_result, pe_valid   registered PE response
//   m_valid/m_ready       output stream handshake
//   m_result, m_error     captured result (0 on error), error flag
//   fifo_count            input FIFO occupancy
//   busy                  FSM not IDLE
module pe_operand_dispatcher #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [3:0]                    s_op,
  input  logic [DATA_WIDTH-1:0]         s_a,
  input  logic [DATA_WIDTH-1:0]         s_b,
  output logic                          pe_enable,
  output logic [3:0]                    pe_operation,
  output logic [DATA_WIDTH-1:0]         pe_op_a,
  output logic [DATA_WIDTH-1:0]         pe_op_b,
  input  logic [DATA_WIDTH-1:0]         pe_result,
  input  logic                          pe_valid,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_result,
  output logic                          m_error,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  function automatic logic op_is_valid(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  logic [3:0]            op_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] a_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] b_mem  [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  state_t                state;
  logic [TW-1:0]         tmo_cnt;
  logic [3:0]            hold_op;
  logic [DATA_WIDTH-1:0] hold_a;
  logic [DATA_WIDTH-1:0] hold_b;

  logic push;
  logic pop;

  // A full FIFO refuses input even when the FSM pops that same cycle.
  assign s_ready = (fifo_count < DEPTH_C) && !rst;
  assign push    = s_valid && s_ready;
  assign pop     = (state == S_IDLE) && (fifo_count != '0);

  assign pe_operation = hold_op;
  assign pe_op_a      = hold_a;
  assign pe_op_b      = hold_b;
  assign busy         = (state != S_IDLE);

  // FIFO storage and pointers; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr] <= s_op;
      a_mem[wr_ptr]  <= s_a;
      b_mem[wr_ptr]  <= s_b;
    end
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Control FSM. pe_enable is decided at the pop so that it is high exactly
  // for the ISSUE cycle of a valid op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pe_enable <= 1'b0;
      tmo_cnt   <= '0;
      hold_op   <= '0;
      hold_a    <= '0;
      hold_b    <= '0;
      m_valid   <= 1'b0;
      m_result  <= '0;
      m_error   <= 1'b0;
    end else begin
      pe_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            hold_op   <= op_mem[rd_ptr];
            hold_a    <= a_mem[rd_ptr];
            hold_b    <= b_mem[rd_ptr];
            pe_enable <= op_is_valid(op_mem[rd_ptr]);
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (op_is_valid(hold_op)) begin
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end else begin
            m_result <= '0;
            m_error  <= 1'b1;
            m_valid  <= 1'b1;
            state    <= S_RESP;
          end
        end
        S_WAIT: begin
          if (pe_valid) begin
            m_result <= pe_result;
            m_error  <= 1'b0;
            m_valid  <= 1'b1;
            state    <= S_RESP;
          end else if (tmo_cnt == TIMEOUT_C) begin
            m_result <= '0;
            m_error  <= 1'b1;
            m_valid  <= 1'b1;
            state    <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_operand_dispatcher.sv
// tb_pe_operand_dispatcher
//   Bench for pe_operand_dispatcher with a behavioural PE stub (registered
//   result, MAC accumulator, optional mute to force timeouts). Expected
//   results are queued at acceptance and compared when the output handshakes.
module tb_pe_operand_dispatcher;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [3:0]    s_op = '0;
  logic [DW-1:0] s_a = '0;
  logic [DW-1:0] s_b = '0;
  logic          pe_enable;
  logic [3:0]    pe_operation;
  logic [DW-1:0] pe_op_a;
  logic [DW-1:0] pe_op_b;
  logic [DW-1:0] pe_result;
  logic          pe_valid;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_result;
  logic          m_error;
  logic [3:0]    fifo_count;
  logic          busy;

  logic          rst_n;
  logic          pe_mute = 1'b0;
  logic [DW-1:0] acc;

  logic [DW-1:0] exp_res_q [$];
  logic          exp_err_q [$];

  int total = 0;
  int bad = 0;
  int n_out = 0;
  int n_en = 0;
  int en_double = 0;
  logic en_prev = 1'b0;

  always #5 clk = ~clk;
  assign rst_n = ~rst;

  pe_operand_dispatcher #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_a(s_a), .s_b(s_b),
    .pe_enable(pe_enable), .pe_operation(pe_operation),
    .pe_op_a(pe_op_a), .pe_op_b(pe_op_b),
    .pe_result(pe_result), .pe_valid(pe_valid),
    .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .m_error(m_error),
    .fifo_count(fifo_count), .busy(busy)
  );

  // PE stub: registered result one cycle after the enabled edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      pe_valid  <= 1'b0;
      pe_result <= '0;
      acc       <= '0;
    end else begin
      pe_valid <= pe_enable && !pe_mute;
      if (pe_enable) begin
        case (pe_operation)
          4'd1: pe_result <= pe_op_a + pe_op_b;
          4'd2: pe_result <= pe_op_a - pe_op_b;
          4'd3: pe_result <= pe_op_a * pe_op_b;
          4'd4: begin
            acc       <= acc + pe_op_a * pe_op_b;
            pe_result <= acc + pe_op_a * pe_op_b;
          end
          default: pe_result <= 32'hDEAD_BEEF;
        endcase
      end
    end
  end

  // Output scoreboard and pe_enable pulse monitor.
  initial begin
    logic [DW-1:0] er;
    logic          ee;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pe_enable === 1'b1) begin
          n_en++;
          if (en_prev) en_double++;
        end
        en_prev = (pe_enable === 1'b1);
        if (m_valid === 1'b1 && m_ready) begin
          n_out++;
          total++;
          if (exp_res_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output result=%0h error=%b required none", m_result, m_error);
          end else begin
            er = exp_res_q.pop_front();
            ee = exp_err_q.pop_front();
            if (m_result !== er || m_error !== ee) begin
              bad++;
              $display("FAIL result #%0d got result=%0h error=%b required result=%0h error=%b",
                       n_out, m_result, m_error, er, ee);
            end
          end
        end
      end else begin
        en_prev = 1'b0;
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] er, input logic ee);
    int guard;
    guard = 0;
    s_valid = 1'b1;
    s_op = op;
    s_a = a;
    s_b = b;
    @(negedge clk);
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL send_accept s_ready=%b required 1 within 200 cycles", s_ready);
    end else begin
      @(posedge clk);
      exp_res_q.push_back(er);
      exp_err_q.push_back(ee);
    end
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_out(input int target, input int limit);
    int guard;
    guard = 0;
    while (n_out < target && guard < limit) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (n_out < target) begin
      bad++;
      $display("FAIL output_count got=%0d required=%0d", n_out, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%b required=0", s_ready); end
    total++; if (pe_enable !== 1'b0) begin bad++; $display("FAIL rst_pe_enable got=%b required=0", pe_enable); end
    total++; if (pe_operation !== 4'd0) begin bad++; $display("FAIL rst_pe_operation got=%0h required=0", pe_operation); end
    total++; if (pe_op_a !== '0 || pe_op_b !== '0) begin bad++; $display("FAIL rst_pe_ops got=%0h/%0h required=0/0", pe_op_a, pe_op_b); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b required=0", m_valid); end
    total++; if (m_result !== '0 || m_error !== 1'b0) begin bad++; $display("FAIL rst_m_result got=%0h/%b required=0/0", m_result, m_error); end
    total++; if (fifo_count !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL rst_count_busy got=%0d/%b required=0/0", fifo_count, busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL post_rst_s_ready got=%b required=1", s_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    int en0;
    en0 = n_en;
    m_ready = 1'b1;
    send(4'd1, 32'd100, 32'd200, 32'd300, 1'b0);
    @(negedge clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL add_e0_m_valid got=%b required=0", m_valid); end
    @(negedge clk);
    total++; if (pe_enable !== 1'b1 || pe_operation !== 4'd1 || pe_op_a !== 32'd100 || pe_op_b !== 32'd200) begin
      bad++; $display("FAIL add_issue en=%b op=%0h a=%0d b=%0d required 1/1/100/200", pe_enable, pe_operation, pe_op_a, pe_op_b);
    end
    @(negedge clk);
    total++; if (m_valid !== 1'b0 || pe_enable !== 1'b0) begin bad++; $display("FAIL add_e2 m_valid=%b en=%b required 0/0", m_valid, pe_enable); end
    @(negedge clk);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL add_latency m_valid=%b required=1 after 3 edges", m_valid); end
    repeat (3) @(negedge clk);
    total++; if (n_en - en0 != 1) begin bad++; $display("FAIL add_enable_pulses got=%0d required=1", n_en - en0); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int base;
    base = n_out;
    m_ready = 1'b1;
    send(4'd4, 32'd2, 32'd3, 32'd6, 1'b0);
    send(4'd4, 32'd4, 32'd5, 32'd26, 1'b0);
    send(4'd4, 32'd1, 32'd10, 32'd36, 1'b0);
    send(4'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    wait_out(base + 4, 100);
    total++; if (en_double != 0) begin bad++; $display("FAIL enable_consecutive got=%0d required=0", en_double); end
    total++; if (exp_res_q.size() != 0) begin bad++; $display("FAIL b2b_pending got=%0d required=0", exp_res_q.size()); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_invalid_op();
    logic [3:0] ops [3];
    int en0;
    ops[0] = 4'h0;
    ops[1] = 4'h5;
    ops[2] = 4'hF;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      en0 = n_en;
      send(ops[i], 32'd7, 32'd9, 32'd0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      total++; if (m_valid !== 1'b0 || pe_enable !== 1'b0) begin
        bad++; $display("FAIL inv_e1 op=%0h m_valid=%b en=%b required 0/0", ops[i], m_valid, pe_enable);
      end
      @(negedge clk);
      total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL inv_latency op=%0h m_valid=%b required=1", ops[i], m_valid); end
      repeat (2) @(negedge clk);
      total++; if (n_en != en0) begin bad++; $display("FAIL inv_enable op=%0h pulses=%0d required=0", ops[i], n_en - en0); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_full();
    int base;
    base = n_out;
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++)
      send(4'd1, 32'(i * 1000 + 7), 32'(i + 3), 32'(i * 1000 + 7 + i + 3), 1'b0);
    @(negedge clk);
    total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d required=8", fifo_count); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL full_s_ready got=%b required=0", s_ready); end
    repeat (4) @(negedge clk);
    total++; if (m_valid !== 1'b1 || busy !== 1'b1 || fifo_count !== 4'd8) begin
      bad++; $display("FAIL full_stall m_valid=%b busy=%b count=%0d required 1/1/8", m_valid, busy, fifo_count);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_out(base + 9, 200);
    repeat (2) @(negedge clk);
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL drain_count got=%0d required=0", fifo_count); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
    int base;
    base = n_out;
    m_ready = 1'b1;
    pe_mute = 1'b1;
    send(4'd3, 32'd10, 32'd20, 32'd0, 1'b1);
    send(4'd1, 32'd5, 32'd6, 32'd11, 1'b0);
    repeat (18) @(negedge clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL tmo_early m_valid=%b required=0", m_valid); end
    @(negedge clk);
    total++; if (m_valid !== 1'b1 || m_error !== 1'b1) begin
      bad++; $display("FAIL tmo_edge m_valid=%b m_error=%b required 1/1", m_valid, m_error);
    end
    pe_mute = 1'b0;
    wait_out(base + 2, 50);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int base;
    base = n_out;
    m_ready = 1'b1;
    pe_mute = 1'b1;
    for (int i = 0; i < 4; i++) send(4'd3, 32'(i + 1), 32'd2, 32'(2 * (i + 1)), 1'b0);
    @(negedge clk);
    total++; if (fifo_count !== 4'd3 || busy !== 1'b1) begin
      bad++; $display("FAIL mid_pre count=%0d busy=%b required 3/1", fifo_count, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_s_ready got=%b required=0", s_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_res_q.delete();
    exp_err_q.delete();
    pe_mute = 1'b0;
    @(negedge clk);
    total++; if (m_valid !== 1'b0 || m_result !== '0 || m_error !== 1'b0) begin
      bad++; $display("FAIL mid_outputs m_valid=%b result=%0h error=%b required 0/0/0", m_valid, m_result, m_error);
    end
    total++; if (pe_enable !== 1'b0 || pe_operation !== 4'd0 || pe_op_a !== '0 || pe_op_b !== '0) begin
      bad++; $display("FAIL mid_pe en=%b op=%0h a=%0h b=%0h required all 0", pe_enable, pe_operation, pe_op_a, pe_op_b);
    end
    total++; if (fifo_count !== 4'd0 || busy !== 1'b0 || s_ready !== 1'b1) begin
      bad++; $display("FAIL mid_state count=%0d busy=%b s_ready=%b required 0/0/1", fifo_count, busy, s_ready);
    end
    repeat (30) @(negedge clk);
    total++; if (n_out != base) begin bad++; $display("FAIL mid_no_output got=%0d required=0", n_out - base); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_invalid_op();
    test_full();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
